// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// A single 1-bit full-add slice (two half adders plus an OR) is stepped
// across WIDTH cycles, LSB first, to add two WIDTH-bit unsigned operands.
//
// Ports:
//   clk    - system clock, rising-edge
//   rst    - asynchronous active-high reset
//   start  - request pulse, sampled only in IDLE
//   A, B   - operands, captured on an accepted start
//   sub    - (SERIAL_SUB_EN only) 1 = compute A-B, captured with A/B
//   S      - sum, loaded on the last RUN edge, held until the next result
//   Cout   - carry out of the MSB (for subtract: 1 = no borrow)
//   busy   - high while in RUN
//   done   - one-cycle pulse in DONE
//
// Optional feature macro: SERIAL_SUB_EN (adds the sub port).
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sub_i;
  logic             h1s, h1c, h2c, sbit, cnx;
  logic             last;

`ifdef SERIAL_SUB_EN
  always_comb sub_i = sub;
`else
  always_comb sub_i = 1'b0;
`endif

  // Full-add slice built from two half adders and an OR.
  always_comb begin
    h1s  = areg[0] ^ breg[0];
    h1c  = areg[0] & breg[0];
    sbit = h1s ^ carry;
    h2c  = h1s & carry;
    cnx  = h1c | h2c;
    last = (cnt == LAST);
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // The A shift register doubles as the sum accumulator: each consumed
  // operand bit frees the MSB slot that receives the new sum bit, so after
  // WIDTH shifts it holds the full sum. S is loaded with that shifted value
  // on the final RUN edge so it only changes once per operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          areg  <= A;
          breg  <= sub_i ? ~B : B;
          carry <= sub_i;
          cnt   <= '0;
        end
        RUN: begin
          areg  <= {sbit, areg[WIDTH-1:1]};
          breg  <= {1'b0, breg[WIDTH-1:1]};
          carry <= cnx;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            S    <= {sbit, areg[WIDTH-1:1]};
            Cout <= cnx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         sub = 1'b0;
  logic [W-1:0] S;
  logic         Cout, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .S(S), .Cout(Cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1..W = running, W+1 = result ready.
  // The expected result is plain arithmetic computed at acceptance.
  int           m_phase = 0;
  logic [W:0]   m_pend = '0;
  logic [W-1:0] m_S = '0;
  logic         m_C = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_S = '0;
      m_C = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        if (sub) m_pend = {1'b0, A} + {1'b0, ~B} + (W+1)'(1);
        else     m_pend = {1'b0, A} + {1'b0, B};
        m_phase = 1;
      end
    end else if (m_phase <= W) begin
      m_phase++;
      if (m_phase == W + 1) begin
        m_S = m_pend[W-1:0];
        m_C = m_pend[W];
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
    check("done", 32'(done), 32'(m_phase == W + 1));
    check("S",    32'(S),    32'(m_S));
    check("Cout", 32'(Cout), 32'(m_C));
  end

  // Issue one start, count busy cycles and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input string name, input logic [W-1:0] exp_s, input logic exp_c);
    int nb;
    bit seen;
    nb = 0;
    seen = 0;
    @(posedge clk); #2;
    start = 1'b1; A = a; B = b; sub = s;
    @(posedge clk); #2;
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin seen = 1; break; end
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(nb), 32'(W));
    check({name, "_S"}, 32'(S), 32'(exp_s));
    check({name, "_Cout"}, 32'(Cout), 32'(exp_c));
  endtask

  initial begin
    #12;
    check("rst_S", 32'(S), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, "add", 8'h7F, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, "ovf", 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b0, "chain", 8'hFE, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, "zero", 8'h00, 1'b0);

    // Mid-run re-start with changed operands must be ignored.
    @(posedge clk); #2;
    start = 1'b1; A = 8'h12; B = 8'h34;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; A = 8'hFF; B = 8'hFF;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("midrun_S", 32'(S), 32'h46);
    check("midrun_Cout", 32'(Cout), 32'd0);

    // Reset during RUN cycle 4: immediate clear, no done pulse.
    @(posedge clk); #2;
    start = 1'b1; A = 8'hAA; B = 8'h55;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_S", 32'(S), 32'd0);
    check("abort_Cout", 32'(Cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    begin
      bit dseen = 0;
      repeat (W + 2) begin @(negedge clk); if (done) dseen = 1; end
      check("abort_no_done", 32'(dseen), 32'd0);
    end
    run_op(8'h10, 8'h20, 1'b0, "post_rst", 8'h30, 1'b0);

`ifdef SERIAL_SUB_EN
    run_op(8'h50, 8'h20, 1'b1, "sub_pos", 8'h30, 1'b1);
    run_op(8'h20, 8'h50, 1'b1, "sub_neg", 8'hD0, 1'b0);
    run_op(8'h35, 8'h4A, 1'b0, "sub0_add", 8'h7F, 1'b0);
`endif

    // Back-to-back: start held high yields one result per W+2 cycles.
    begin
      int nd = 0;
      @(posedge clk); #2;
      start = 1'b1; A = 8'h03; B = 8'h04; sub = 1'b0;
      repeat (3 * (W + 2)) begin @(negedge clk); if (done) nd++; end
      start = 1'b0;
      check("b2b_done_count", 32'(nd), 32'd3);
      check("b2b_S", 32'(S), 32'h07);
    end
    repeat (2 * W) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
